regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the single-write/dual-read file in the processor datapath. Provides:
- configurable width, depth and read-port count
- two write ports with fixed priority
- optional hardwired-zero entry 0
- sequential bulk-clear state machine with a busy/done handshake
It sits between decode (read addresses) and writeback (ALU and load-return write ports).

Parameters:
DATA_W, 32, bits per register
DEPTH, 32, number of registers (power of two, >=4)
NUM_RD, 2, number of asynchronous read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rg_wrt_en0  input  1  write port 0 enable (ALU writeback)
rg_wrt_addr0  input  AW  write port 0 address, AW = $clog2(DEPTH)
rg_wrt_data0  input  DATA_W  write port 0 data
rg_wrt_en1  input  1  write port 1 enable (load return; higher priority)
rg_wrt_addr1  input  AW  write port 1 address
rg_wrt_data1  input  DATA_W  write port 1 data
rg_rd_addr  input  NUM_RD*AW  packed read addresses; port k = bits [k*AW +: AW]
rg_rd_data  output  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
rg_clr_req  input  1  single-cycle request to zero the whole file
rg_clr_busy  output  1  clear sequence in progress
rg_clr_done  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset (reset==0, asynchronous):
  - all entries = 0; FSM = IDLE; clear counter = 0
  - rg_clr_busy = 0, rg_clr_done = 0
  - rg_rd_data = 0 on every port
- Writes: registered on the rising clk edge.
  - en0 and en1 to different addresses: both are written.
  - Same address: port 1 data wins; port 0 is dropped.
- ZERO_REG=1:
  - writes to address 0 are ignored
  - reads of address 0 return 0 regardless of storage
- Reads: combinational, zero latency from rg_rd_addr to rg_rd_data; they return the value committed at the previous edge.
- Read-after-write in the same cycle returns OLD data unless REGFILE_BYPASS_EN is defined.
- Clear FSM, states IDLE, CLEAR:
  - IDLE, rg_clr_req=1: go to CLEAR; counter = (ZERO_REG ? 1 : 0); busy=1 from the next cycle.
  - CLEAR: each cycle zero entry[counter], counter+1. When counter == DEPTH-1 is zeroed, go to IDLE; busy=0 and done=1 for exactly one cycle in the following cycle.
  - Clear duration: DEPTH-ZERO_REG cycles of busy.
  - While busy: both write enables are ignored (writeback must stall on rg_clr_busy). Reads remain live and return a mix of cleared/uncleared entries.
  - rg_clr_req while busy: ignored; no restart, no queueing.
  - rg_clr_req in the cycle done pulses: accepted; a new CLEAR starts.
  - Write and rg_clr_req in the same IDLE cycle: the write commits. The clear then overwrites that entry later.
- Reset mid-clear: immediate abort. Everything is zero, FSM = IDLE, no done pulse.
- Address arithmetic is unsigned, AW bits wide. The counter never wraps past DEPTH-1.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address matches an enabled write address in the same cycle returns the incoming write data. Port 1 has priority over port 0. The bypass is suppressed for address 0 when ZERO_REG=1, and suppressed while rg_clr_busy.
- Undefined: no forwarding; reads return stored data only. Reads are purely the array lookup.

Decomposition:
- Package regfile_pkg:
  - clear-FSM state typedef (IDLE, CLEAR)
  - localparam helper for AW
  - default width/depth constants shared with decode and writeback
- One natural sub-module: regfile_clr_fsm. Holds the state, the counter, busy/done and the clear address/strobe, and drives a clear-write into the array. The array, write-priority, zero-reg and bypass logic stay in regfile_mp.

Test Plan:
- Reset release, then read all 32 addresses on 2 ports -> every rg_rd_data = 0x00000000; busy=0, done=0.
- Write port 0: addr 5 = 0xDEADBEEF; next cycle read addr 5 on port 1 -> 0xDEADBEEF. Write addr 0 = 0x1234 -> reads 0 (ZERO_REG=1).
- Same cycle: en0 addr 7 = 0x11111111 and en1 addr 7 = 0x22222222 -> addr 7 reads 0x22222222. Different addresses 8/9 -> both stored.
- Fill entries 1..31 with their index, pulse rg_clr_req:
  - busy is high for exactly 31 cycles; done pulses once.
  - writes during busy are dropped.
  - all entries read 0 after done.
  - second req mid-clear causes no extension.
- Clear in progress at cycle 10, assert reset=0 -> busy=0 immediately, no done pulse, all reads 0.
- REGFILE_BYPASS_EN defined: write addr 3 = 0xCAFEF00D while reading addr 3 on port 0 -> same-cycle data 0xCAFEF00D. Undefined -> old value 0x00000003.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 32;
    localparam int unsigned DEF_NUM_RD = 2;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks the file one entry per cycle and
// drives a zeroing write into the array, with busy/done handshake.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rg_clr_req,
    output logic                       rg_clr_busy,
    output logic                       rg_clr_done,
    output logic                       clr_we_c,
    output logic [addr_w(DEPTH)-1:0]   clr_addr_c
);

    localparam int unsigned AW = addr_w(DEPTH);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Requests arriving while CLEAR are dropped; the done cycle is IDLE so a
    // request there starts a fresh sweep.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        clr_we_c   = 1'b0;
        clr_addr_c = cnt_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (rg_clr_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = (ZERO_REG != 0) ? AW'(1) : '0;
                end
            end
            CLR_CLEAR: begin
                clr_we_c = 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = CLR_IDLE;
        endcase
        busy_d = (state_d == CLR_CLEAR);
    end

    assign rg_clr_busy = busy_q;
    assign rg_clr_done = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD async reads,
// optional hardwired zero entry and bulk clear. Define REGFILE_BYPASS_EN to
// forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rg_wrt_en0,
    input  logic [addr_w(DEPTH)-1:0]          rg_wrt_addr0,
    input  logic [DATA_W-1:0]                 rg_wrt_data0,
    input  logic                              rg_wrt_en1,
    input  logic [addr_w(DEPTH)-1:0]          rg_wrt_addr1,
    input  logic [DATA_W-1:0]                 rg_wrt_data1,
    input  logic [NUM_RD*addr_w(DEPTH)-1:0]   rg_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]          rg_rd_data,
    input  logic                              rg_clr_req,
    output logic                              rg_clr_busy,
    output logic                              rg_clr_done
);

    localparam int unsigned AW = addr_w(DEPTH);

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic                     clr_we_c;
    logic [AW-1:0]            clr_addr_c;
    logic                     wr0_ok_c;
    logic                     wr1_ok_c;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [AW-1:0]            ra;
    logic [DATA_W-1:0]        rv;

    regfile_clr_fsm #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_clr_fsm (
        .clk         (clk),
        .reset       (reset),
        .rg_clr_req  (rg_clr_req),
        .rg_clr_busy (rg_clr_busy),
        .rg_clr_done (rg_clr_done),
        .clr_we_c    (clr_we_c),
        .clr_addr_c  (clr_addr_c)
    );

    // Writeback is locked out for the whole sweep; entry 0 is read-only when hardwired.
    assign wr0_ok_c = rg_wrt_en0 && !rg_clr_busy && !((ZERO_REG != 0) && (rg_wrt_addr0 == '0));
    assign wr1_ok_c = rg_wrt_en1 && !rg_clr_busy && !((ZERO_REG != 0) && (rg_wrt_addr1 == '0));

    // Port 1 is applied last so it wins on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_we_c) begin
            mem_d[clr_addr_c] = '0;
        end else begin
            if (wr0_ok_c) mem_d[rg_wrt_addr0] = rg_wrt_data0;
            if (wr1_ok_c) mem_d[rg_wrt_addr1] = rg_wrt_data1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data_c = '0;
        ra        = '0;
        rv        = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rg_rd_addr[k*AW +: AW];
            rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr1_ok_c && (rg_wrt_addr1 == ra)) begin
                rv = rg_wrt_data1;
            end else if (wr0_ok_c && (rg_wrt_addr0 == ra)) begin
                rv = rg_wrt_data0;
            end
`endif
            if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
            rd_data_c[k*DATA_W +: DATA_W] = rv;
        end
    end

    assign rg_rd_data = rd_data_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes model expectations, monitor compares.
module tb_regfile_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned ZERO  = 1;
    localparam int unsigned AW    = 5;

    logic                clk;
    logic                reset;
    logic                rg_wrt_en0;
    logic [AW-1:0]       rg_wrt_addr0;
    logic [DW-1:0]       rg_wrt_data0;
    logic                rg_wrt_en1;
    logic [AW-1:0]       rg_wrt_addr1;
    logic [DW-1:0]       rg_wrt_data1;
    logic [NRD*AW-1:0]   rg_rd_addr;
    logic [NRD*DW-1:0]   rg_rd_data;
    logic                rg_clr_req;
    logic                rg_clr_busy;
    logic                rg_clr_done;

    regfile_mp #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .NUM_RD   (NRD),
        .ZERO_REG (ZERO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rg_wrt_en0   (rg_wrt_en0),
        .rg_wrt_addr0 (rg_wrt_addr0),
        .rg_wrt_data0 (rg_wrt_data0),
        .rg_wrt_en1   (rg_wrt_en1),
        .rg_wrt_addr1 (rg_wrt_addr1),
        .rg_wrt_data1 (rg_wrt_data1),
        .rg_rd_addr   (rg_rd_addr),
        .rg_rd_data   (rg_rd_data),
        .rg_clr_req   (rg_clr_req),
        .rg_clr_busy  (rg_clr_busy),
        .rg_clr_done  (rg_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*DW-1:0] rd;
        logic              busy;
        logic              done;
        int                cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;

    // Reference model: plain array plus "how many clear cycles remain".
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy_left;
    int            m_clr_idx;
    logic          m_done;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, expv);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_busy_left = 0;
        m_clr_idx   = 0;
        m_done      = 1'b0;
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a,
        input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        if (ZERO != 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (m_busy_left == 0) begin
            if (e1 && a1 == a) return d1;
            if (e0 && a0 == a) return d0;
        end
`endif
        return m_mem[a];
    endfunction

    // Drive one cycle of inputs (called at posedge+1), record expectation, advance model.
    task automatic step(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic req, input logic [NRD*AW-1:0] ra);
        exp_t e;
        rg_wrt_en0 = e0; rg_wrt_addr0 = a0; rg_wrt_data0 = d0;
        rg_wrt_en1 = e1; rg_wrt_addr1 = a1; rg_wrt_data1 = d1;
        rg_clr_req = req; rg_rd_addr = ra;
        e.busy = (m_busy_left != 0);
        e.done = m_done;
        e.cyc  = cyc;
        for (int k = 0; k < int'(NRD); k++)
            e.rd[k*DW +: DW] = m_read(ra[k*AW +: AW], e0, a0, d0, e1, a1, d1);
        exp_q.push_back(e);
        if (m_busy_left > 0) begin
            m_mem[m_clr_idx] = '0;
            m_clr_idx++;
            m_busy_left--;
            m_done = (m_busy_left == 0);
        end else begin
            if (e0 && !(ZERO != 0 && a0 == 0)) m_mem[a0] = d0;
            if (e1 && !(ZERO != 0 && a1 == 0)) m_mem[a1] = d1;
            m_done = 1'b0;
            if (req) begin
                m_busy_left = int'(DEPTH - ZERO);
                m_clr_idx   = int'(ZERO);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [NRD*AW-1:0] ra);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ra);
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, a, d, 1'b0, '0, '0, 1'b0, '0);
    endtask

    function automatic logic [NRD*AW-1:0] rd2(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        return {p1, p0};
    endfunction

    // Direct constant check of one read port with writes quiesced (no clock edge crossed).
    task automatic peek(input string name, input int port, input logic [AW-1:0] a, input logic [DW-1:0] expv);
        rg_wrt_en0 = 1'b0; rg_wrt_en1 = 1'b0; rg_clr_req = 1'b0;
        rg_rd_addr[port*AW +: AW] = a;
        #1;
        check(name, 64'(rg_rd_data[port*DW +: DW]), 64'(expv));
    endtask

    // Monitor: compare DUT outputs against queued expectations on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rg_clr_busy) busy_cnt++;
            if (rg_clr_done) done_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("rd_data c%0d", e.cyc), 64'(rg_rd_data), 64'(e.rd));
                check($sformatf("busy c%0d", e.cyc), 64'(rg_clr_busy), 64'(e.busy));
                check($sformatf("done c%0d", e.cyc), 64'(rg_clr_done), 64'(e.done));
            end
        end
    end

    initial begin
        logic [NRD*AW-1:0] ra;
        reset = 1'b0;
        rg_wrt_en0 = 1'b0; rg_wrt_addr0 = '0; rg_wrt_data0 = '0;
        rg_wrt_en1 = 1'b0; rg_wrt_addr1 = '0; rg_wrt_data1 = '0;
        rg_clr_req = 1'b0; rg_rd_addr = '0;
        m_reset();
        #1;
        check("reset busy", 64'(rg_clr_busy), 64'd0);
        check("reset done", 64'(rg_clr_done), 64'd0);
        check("reset rd_data", 64'(rg_rd_data), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) idle(rd2(AW'(i), AW'(i)));

        wr0(5'd5, 32'hDEADBEEF);
        idle(rd2(5'd0, 5'd5));
        peek("rd addr5 port1", 1, 5'd5, 32'hDEADBEEF);
        wr0(5'd0, 32'h00001234);
        idle(rd2(5'd0, 5'd0));
        peek("zero reg read", 0, 5'd0, 32'h0);

        step(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, '0);
        idle(rd2(5'd7, 5'd7));
        peek("same addr port1 wins", 0, 5'd7, 32'h22222222);
        step(1'b1, 5'd8, 32'h88888888, 1'b1, 5'd9, 32'h99999999, 1'b0, '0);
        idle(rd2(5'd8, 5'd9));
        peek("diff addr port0", 0, 5'd8, 32'h88888888);

        // Bulk clear with stalled-but-asserted writeback and a second request mid-sweep.
        for (int i = 1; i < int'(DEPTH); i++) wr0(AW'(i), DW'(i));
        busy_cnt = 0;
        done_cnt = 0;
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, rd2(5'd1, 5'd2));
        for (int j = 0; j < 40; j++) begin
            ra = rd2(AW'($urandom_range(DEPTH - 1)), AW'($urandom_range(DEPTH - 1)));
            if (j < 28)
                step(1'b1, AW'($urandom_range(DEPTH - 1)), $urandom, 1'b1, AW'($urandom_range(DEPTH - 1)),
                     $urandom, (j == 10), ra);
            else
                idle(ra);
        end
        check("busy cycle count", 64'(busy_cnt), 64'd31);
        check("done pulse count", 64'(done_cnt), 64'd1);
        for (int i = 0; i < int'(DEPTH); i++) idle(rd2(AW'(i), AW'(DEPTH - 1 - i)));
        peek("post-clear addr31", 0, 5'd31, 32'h0);

        wr0(5'd3, 32'h00000003);
        rg_wrt_en0 = 1'b1; rg_wrt_addr0 = 5'd3; rg_wrt_data0 = 32'hCAFEF00D;
        rg_wrt_en1 = 1'b0; rg_clr_req = 1'b0; rg_rd_addr = rd2(5'd3, 5'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass same-cycle", 64'(rg_rd_data[DW-1:0]), 64'h00000000CAFEF00D);
`else
        check("no bypass old data", 64'(rg_rd_data[DW-1:0]), 64'h0000000000000003);
`endif
        wr0(5'd3, 32'hCAFEF00D);
        idle(rd2(5'd3, 5'd3));

        for (int n = 0; n < 1200; n++) begin
            step($urandom_range(3) != 0, AW'($urandom_range(DEPTH - 1)), $urandom,
                 $urandom_range(2) == 0, AW'($urandom_range(DEPTH - 1)), $urandom,
                 $urandom_range(60) == 0,
                 rd2(AW'($urandom_range(DEPTH - 1)), AW'($urandom_range(DEPTH - 1))));
        end

        // Reset in the middle of a clear sweep.
        for (int i = 1; i < int'(DEPTH); i++) idle('0);
        for (int i = 1; i < int'(DEPTH); i++) wr0(AW'(i), DW'(i) | 32'hA0000000);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, '0);
        for (int j = 0; j < 10; j++) idle(rd2(AW'(j), AW'(31 - j)));
        #6;
        reset = 1'b0;
        rg_wrt_en0 = 1'b0; rg_wrt_en1 = 1'b0; rg_clr_req = 1'b0;
        #1;
        check("mid-clear reset busy", 64'(rg_clr_busy), 64'd0);
        check("mid-clear reset done", 64'(rg_clr_done), 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rg_rd_addr = rd2(AW'(i), AW'(i));
            #1;
            check($sformatf("mid-clear reset rd %0d", i), 64'(rg_rd_data), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_reset();
        for (int j = 0; j < 40; j++) idle(rd2(AW'(j % 32), AW'(31 - (j % 32))));
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(1) != 0, AW'($urandom_range(DEPTH - 1)), $urandom,
                 $urandom_range(1) != 0, AW'($urandom_range(DEPTH - 1)), $urandom,
                 $urandom_range(80) == 0,
                 rd2(AW'($urandom_range(DEPTH - 1)), AW'($urandom_range(DEPTH - 1))));
        end

        @(negedge clk); #1;
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
